blink_mem_arb: RTL and testbench

Memory-bus arbiter in the Blink gate array that shares the single physical memory port (ma, OE, WE) between Z80 accesses and the LCD screen-fetch engine. It runs every access as a fixed-length slot on the master clock. CPU accesses win by default, and the LCD fetcher has bounded starvation. When the LCD holds the bus, the Z80 is stalled through cpu_wait_n.

---
 rtl/blink_mem_arb_pkg.sv | 20 ++
 rtl/blink_mem_arb_if.sv | 29 ++
 rtl/blink_mem_arb.sv | 103 ++++++++++
 tb/tb_blink_mem_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_mem_arb_pkg.sv
// Shared Blink definitions: physical address width, arbiter state encoding,
// idle bus address and the default memory slot length.
package blink_mem_arb_pkg;

  localparam int PA_W           = 22;
  localparam int ACC_CYCLES_DEF = 3;
  localparam logic [PA_W-1:0] MA_IDLE = 22'h3FFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    LCD  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [PA_W-1:0] addr;
    logic            wr;
  } mem_req_t;

endpackage

// File: rtl/blink_mem_arb_if.sv
// Requester handshakes plus the shared physical memory port.
// The arbiter takes the master side because it drives the memory pins.
interface blink_mem_arb_if import blink_mem_arb_pkg::*; ();

  logic            cpu_req;
  logic [PA_W-1:0] cpu_ma;
  logic            cpu_wr;
  logic            cpu_ack;
  logic            cpu_wait_n;
  logic            lcd_req;
  logic [PA_W-1:0] lcd_ma;
  logic            lcd_ack;
  logic [7:0]      lcd_data;
  logic [PA_W-1:0] ma;
  logic            mem_oe_n;
  logic            mem_we_n;
  logic [7:0]      mem_di;

  modport master (
    input  cpu_req, cpu_ma, cpu_wr, lcd_req, lcd_ma, mem_di,
    output cpu_ack, cpu_wait_n, lcd_ack, lcd_data, ma, mem_oe_n, mem_we_n
  );

  modport slave (
    output cpu_req, cpu_ma, cpu_wr, lcd_req, lcd_ma, mem_di,
    input  cpu_ack, cpu_wait_n, lcd_ack, lcd_data, ma, mem_oe_n, mem_we_n
  );

endinterface

// File: rtl/blink_mem_arb.sv
// Memory-port arbiter: fixed-length slots shared between the Z80 and the LCD
// fetcher. CPU wins contention until the LCD has lost STARVE_MAX times in a row.
module blink_mem_arb import blink_mem_arb_pkg::*; #(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic             mck,
  input  logic             rin_n,
  blink_mem_arb_if.master  bus
);

  localparam int AW = $clog2(ACC_CYCLES);
  localparam logic [AW-1:0] LAST   = AW'(ACC_CYCLES - 1);
  localparam logic [AW-1:0] WE_END = AW'(ACC_CYCLES - 2);
  localparam logic [2:0]    SMAX   = 3'(STARVE_MAX);

  arb_state_e    state;
  logic [AW-1:0] acc_cnt;
  logic [AW-1:0] acc_nxt;
  logic [2:0]    starve_cnt;
  logic          slot_wr;
  logic          lcd_wins;
  mem_req_t      win;

  assign acc_nxt  = acc_cnt + AW'(1);
  assign lcd_wins = bus.lcd_req & (~bus.cpu_req | (starve_cnt == SMAX));

  always_comb begin
    win.addr = bus.cpu_ma;
    win.wr   = bus.cpu_wr;
    if (lcd_wins) begin
      win.addr = bus.lcd_ma;
      win.wr   = 1'b0;
    end
  end

  // Wait drops out on the ack itself so the Z80 sees the slot end without a gap.
  assign bus.cpu_wait_n = ~(bus.cpu_req & (state != CPU) & ~bus.cpu_ack);

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      state        <= IDLE;
      acc_cnt      <= '0;
      starve_cnt   <= '0;
      slot_wr      <= 1'b0;
      bus.ma       <= MA_IDLE;
      bus.mem_oe_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
      bus.cpu_ack  <= 1'b0;
      bus.lcd_ack  <= 1'b0;
      bus.lcd_data <= 8'h00;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.lcd_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cpu_req | bus.lcd_req) begin
            state        <= lcd_wins ? LCD : CPU;
            acc_cnt      <= '0;
            bus.ma       <= win.addr;
            slot_wr      <= win.wr;
            bus.mem_oe_n <= win.wr;
            bus.mem_we_n <= 1'b1;
          end
        end
        CPU, LCD: begin
          if (acc_cnt == LAST) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            bus.ma       <= MA_IDLE;
            bus.mem_oe_n <= 1'b1;
            bus.mem_we_n <= 1'b1;
          end else begin
            acc_cnt      <= acc_nxt;
            // WE spans the inner cycles only: one cycle of address setup and hold.
            bus.mem_we_n <= ~(slot_wr & (acc_nxt <= WE_END));
            // Ack and data are registered together so both are valid in the last cycle.
            if (acc_nxt == LAST) begin
              if (state == LCD) begin
                bus.lcd_ack  <= 1'b1;
                bus.lcd_data <= bus.mem_di;
              end else begin
                bus.cpu_ack  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (!bus.lcd_req)
        starve_cnt <= '0;
      else if (state == IDLE) begin
        if (lcd_wins)
          starve_cnt <= '0;
        else if (starve_cnt != SMAX)
          starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_blink_mem_arb.sv
// Bench for blink_mem_arb: directed vector table, contention/pre-emption
// sequences, then random requesters checked against a slot-level model.
module tb_blink_mem_arb;
  import blink_mem_arb_pkg::*;

  localparam int ACC  = 3;
  localparam int SMAX = 4;

  logic mck = 1'b0;
  logic rin_n;
  always #5 mck = ~mck;

  blink_mem_arb_if bus ();

  blink_mem_arb #(.ACC_CYCLES(ACC), .STARVE_MAX(SMAX)) dut (
    .mck   (mck),
    .rin_n (rin_n),
    .bus   (bus)
  );

  function automatic logic [7:0] memf(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  assign bus.mem_di = memf(bus.ma);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slot-level reference: who owns the port, how far into the slot, and LCD debt.
  int          m_own;   // 0 none, 1 cpu, 2 lcd
  int          m_off;
  int          m_starve;
  logic [21:0] m_addr;
  bit          m_wr;
  logic [7:0]  m_ld;
  bit          li_r, li_cr, li_cw, li_lr;
  logic [21:0] li_ca, li_la;

  typedef struct {
    logic [21:0] ma;
    logic oe_n, we_n, cack, lack, wait_n;
    logic [7:0] ld;
  } exp_t;

  function automatic void model_reset();
    m_own = 0; m_off = 0; m_starve = 0; m_addr = MA_IDLE; m_wr = 0; m_ld = 8'h00;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit last;
    last     = (m_off == ACC - 1);
    e.ma     = (m_own != 0) ? m_addr : MA_IDLE;
    e.oe_n   = !(m_own != 0 && !m_wr);
    e.we_n   = !(m_own != 0 && m_wr && m_off >= 1 && m_off <= ACC - 2);
    e.cack   = (m_own == 1) && last;
    e.lack   = (m_own == 2) && last;
    e.wait_n = !(li_cr && m_own != 1 && !e.cack);
    e.ld     = m_ld;
    return e;
  endfunction

  function automatic void model_adv();
    int ns;
    bit lw;
    if (!li_r) begin
      model_reset();
      return;
    end
    ns = m_starve;
    if (m_own != 0) begin
      if (m_off == ACC - 1) m_own = 0;
      else begin
        m_off++;
        if (m_own == 2 && m_off == ACC - 1) m_ld = memf(m_addr);
      end
    end else if (li_cr || li_lr) begin
      lw     = li_lr && (!li_cr || m_starve == SMAX);
      m_own  = lw ? 2 : 1;
      m_off  = 0;
      m_addr = lw ? li_la : li_ca;
      m_wr   = lw ? 1'b0 : li_cw;
      if (lw) ns = 0;
      else if (li_lr) ns = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    end
    if (!li_lr) ns = 0;
    m_starve = ns;
  endfunction

  task automatic drive_cmp(input bit r, cr, cw, input logic [21:0] ca,
                           input bit lr, input logic [21:0] la);
    exp_t e;
    li_r = r; li_cr = cr; li_cw = cw; li_ca = ca; li_lr = lr; li_la = la;
    rin_n = r; bus.cpu_req = cr; bus.cpu_wr = cw; bus.cpu_ma = ca;
    bus.lcd_req = lr; bus.lcd_ma = la;
    #1;
    e = model_out();
    chk("ma",         32'(bus.ma),         32'(e.ma));
    chk("mem_oe_n",   32'(bus.mem_oe_n),   32'(e.oe_n));
    chk("mem_we_n",   32'(bus.mem_we_n),   32'(e.we_n));
    chk("cpu_ack",    32'(bus.cpu_ack),    32'(e.cack));
    chk("lcd_ack",    32'(bus.lcd_ack),    32'(e.lack));
    chk("cpu_wait_n", 32'(bus.cpu_wait_n), 32'(e.wait_n));
    chk("lcd_data",   32'(bus.lcd_data),   32'(e.ld));
  endtask

  task automatic tick();
    model_adv();
    @(posedge mck);
    #1;
  endtask

  task automatic step(input bit r, cr, cw, input logic [21:0] ca,
                      input bit lr, input logic [21:0] la);
    drive_cmp(r, cr, cw, ca, lr, la);
    tick();
  endtask

  typedef struct {
    bit r, cr, cw; logic [21:0] ca; bit lr; logic [21:0] la;
    logic [21:0] ma; bit oe, we, cak, lak, wt; logic [7:0] ld;
  } vec_t;

  function automatic vec_t v(bit r, cr, cw, logic [21:0] ca, bit lr, logic [21:0] la,
                             logic [21:0] ma, bit oe, we, cak, lak, wt, logic [7:0] ld);
    vec_t x;
    x.r = r; x.cr = cr; x.cw = cw; x.ca = ca; x.lr = lr; x.la = la;
    x.ma = ma; x.oe = oe; x.we = we; x.cak = cak; x.lak = lak; x.wt = wt; x.ld = ld;
    return x;
  endfunction

  localparam logic [21:0] I_ = 22'h3FFFFF, A_ = 22'h200100, W_ = 22'h000010;
  localparam logic [21:0] L_ = 22'h0000A5, R_ = 22'h000123, Z_ = 22'h0;

  initial begin
    vec_t tbl[24];
    rin_n = 1'b0;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_ma = '0; bus.lcd_req = 0; bus.lcd_ma = '0;
    li_cr = 0;
    repeat (3) @(posedge mck);
    #1;
    model_reset();

    // Reset state and a quiet bus for 20 cycles
    repeat (20) step(1, 0, 0, Z_, 0, Z_);

    //           r cr cw ca  lr la   ma  oe we ca la wt ld
    tbl[0]  = v(1, 0, 0, Z_, 0, Z_, I_, 1, 1, 0, 0, 1, 8'h00);
    tbl[1]  = v(1, 1, 0, A_, 0, Z_, I_, 1, 1, 0, 0, 0, 8'h00);
    tbl[2]  = v(1, 1, 0, A_, 0, Z_, A_, 0, 1, 0, 0, 1, 8'h00);
    tbl[3]  = v(1, 1, 0, A_, 0, Z_, A_, 0, 1, 0, 0, 1, 8'h00);
    tbl[4]  = v(1, 1, 0, A_, 0, Z_, A_, 0, 1, 1, 0, 1, 8'h00);
    tbl[5]  = v(1, 0, 0, Z_, 0, Z_, I_, 1, 1, 0, 0, 1, 8'h00);
    tbl[6]  = v(1, 1, 1, W_, 0, Z_, I_, 1, 1, 0, 0, 0, 8'h00);
    tbl[7]  = v(1, 1, 1, W_, 0, Z_, W_, 1, 1, 0, 0, 1, 8'h00);
    tbl[8]  = v(1, 1, 1, W_, 0, Z_, W_, 1, 0, 0, 0, 1, 8'h00);
    tbl[9]  = v(1, 1, 1, W_, 0, Z_, W_, 1, 1, 1, 0, 1, 8'h00);
    tbl[10] = v(1, 0, 0, Z_, 0, Z_, I_, 1, 1, 0, 0, 1, 8'h00);
    tbl[11] = v(1, 0, 0, Z_, 1, L_, I_, 1, 1, 0, 0, 1, 8'h00);
    tbl[12] = v(1, 0, 0, Z_, 1, L_, L_, 0, 1, 0, 0, 1, 8'h00);
    tbl[13] = v(1, 0, 0, Z_, 1, L_, L_, 0, 1, 0, 0, 1, 8'h00);
    tbl[14] = v(1, 0, 0, Z_, 1, L_, L_, 0, 1, 0, 1, 1, 8'hA5);
    tbl[15] = v(1, 0, 0, Z_, 0, Z_, I_, 1, 1, 0, 0, 1, 8'hA5);
    tbl[16] = v(1, 1, 1, R_, 0, Z_, I_, 1, 1, 0, 0, 0, 8'hA5);
    tbl[17] = v(1, 1, 1, R_, 0, Z_, R_, 1, 1, 0, 0, 1, 8'hA5);
    tbl[18] = v(0, 1, 1, R_, 0, Z_, R_, 1, 0, 0, 0, 1, 8'hA5);
    tbl[19] = v(1, 1, 1, R_, 0, Z_, I_, 1, 1, 0, 0, 0, 8'h00);
    tbl[20] = v(1, 1, 1, R_, 0, Z_, R_, 1, 1, 0, 0, 1, 8'h00);
    tbl[21] = v(1, 1, 1, R_, 0, Z_, R_, 1, 0, 0, 0, 1, 8'h00);
    tbl[22] = v(1, 1, 1, R_, 0, Z_, R_, 1, 1, 1, 0, 1, 8'h00);
    tbl[23] = v(1, 0, 0, Z_, 0, Z_, I_, 1, 1, 0, 0, 1, 8'h00);

    for (int i = 0; i < 24; i++) begin
      drive_cmp(tbl[i].r, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].lr, tbl[i].la);
      chk($sformatf("vec%0d_ma", i),   32'(bus.ma),         32'(tbl[i].ma));
      chk($sformatf("vec%0d_oe", i),   32'(bus.mem_oe_n),   32'(tbl[i].oe));
      chk($sformatf("vec%0d_we", i),   32'(bus.mem_we_n),   32'(tbl[i].we));
      chk($sformatf("vec%0d_cack", i), 32'(bus.cpu_ack),    32'(tbl[i].cak));
      chk($sformatf("vec%0d_lack", i), 32'(bus.lcd_ack),    32'(tbl[i].lak));
      chk($sformatf("vec%0d_wait", i), 32'(bus.cpu_wait_n), 32'(tbl[i].wt));
      chk($sformatf("vec%0d_ld", i),   32'(bus.lcd_data),   32'(tbl[i].ld));
      tick();
    end

    // Both requesters saturating: grants go CPU x4, LCD x1, repeating
    begin
      byte q[$];
      int guard = 0, lslot = 0, lwait = 0;
      logic [21:0] ca = 22'h012345, la = 22'h0ABCDE;
      repeat (2) step(0, 0, 0, Z_, 0, Z_);
      while (q.size() < 15 && guard < 200) begin
        drive_cmp(1, 1, 0, ca, 1, la);
        if (bus.cpu_ack) q.push_back("C");
        if (bus.lcd_ack) begin
          q.push_back("L");
          chk("lcd_data_at_ack", 32'(bus.lcd_data), 32'(memf(la)));
        end
        if (bus.ma == la) begin
          lslot++;
          if (!bus.cpu_wait_n) lwait++;
        end
        tick();
        guard++;
      end
      chk("contention_done", 32'(guard < 200), 32'd1);
      for (int i = 0; i < q.size(); i++)
        chk($sformatf("grant%0d", i), 32'(q[i]), (i % 5 == 4) ? 32'("L") : 32'("C"));
      chk("lcd_slot_cycles", 32'(lslot), 32'(3 * ACC));
      chk("wait_low_in_lcd", 32'(lwait), 32'(3 * ACC));
    end

    // LCD stream, CPU raised mid-slot: LCD finishes, CPU goes next
    begin
      byte q[$];
      int guard = 0, wlow = 0;
      bit seen = 0;
      logic [21:0] ca = 22'h155555, la = 22'h022222;
      repeat (2) step(0, 0, 0, Z_, 0, Z_);
      while (!(seen && bus.ma == la) && guard < 40) begin
        if (bus.lcd_ack) seen = 1;
        step(1, 0, 0, Z_, 1, la);
        guard++;
      end
      step(1, 0, 0, Z_, 1, la);
      while (!bus.cpu_ack && guard < 80) begin
        drive_cmp(1, 1, 0, ca, 1, la);
        if (bus.lcd_ack) q.push_back("L");
        if (bus.cpu_ack) q.push_back("C");
        if (bus.ma != ca && !bus.cpu_wait_n) wlow++;
        tick();
        guard++;
      end
      chk("preempt_done", 32'(guard < 80), 32'd1);
      chk("preempt_acks", 32'(q.size()), 32'd1);
      if (q.size() > 0) chk("preempt_first", 32'(q[0]), 32'("L"));
      chk("preempt_wait_low", 32'(wlow), 32'(ACC));
    end

    // Random well-behaved requesters with occasional drops and resets
    begin
      bit cr = 0, cw = 0, lr = 0, r;
      logic [21:0] ca = '0, la = '0;
      repeat (2) step(0, 0, 0, Z_, 0, Z_);
      for (int n = 0; n < 1500; n++) begin
        if (cr) begin
          if (m_own == 1 && m_off == ACC - 1) begin
            if ($urandom_range(0, 1) == 0) cr = 0;
            else begin ca = 22'($urandom); cw = 1'($urandom); end
          end else if ($urandom_range(0, 15) == 0) cr = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          cr = 1; ca = 22'($urandom); cw = 1'($urandom);
        end
        if (lr) begin
          if (m_own == 2 && m_off == ACC - 1) begin
            if ($urandom_range(0, 1) == 0) lr = 0;
            else la = 22'($urandom);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          lr = 1; la = 22'($urandom);
        end
        r = ($urandom_range(0, 149) != 0);
        step(r, cr, cw, ca, lr, la);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
